// File: rtl/rs_line_1_to_16_pkg.sv
// Shared width helpers for the RS encoder datapath (distributor, pointer, reducer).
// Index widths never collapse to zero bits, even for a single unit or a single line per block.
package rs_encoder_pkg;

    localparam int DEF_NUM_RS_UNITS = 16;
    localparam int DEF_DATA_W       = 256;
    localparam int DEF_NUM_LINES    = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rs_unit_idx_w(input int num_rs_units);
        return idx_w(num_rs_units);
    endfunction

    function automatic int line_cnt_w(input int num_lines);
        return idx_w(num_lines);
    endfunction

endpackage

// File: rtl/rs_line_1_to_16_if.sv
// Bundle of the upstream line handshake and the per-unit encoder handshake.
// master: the distributor's view. slave: the surrounding environment's view.
interface rs_line_1_to_16_if
    import rs_encoder_pkg::*;
#(
    parameter int NUM_RS_UNITS = DEF_NUM_RS_UNITS,
    parameter int DATA_W       = DEF_DATA_W
);
    localparam int UNIT_W = rs_unit_idx_w(NUM_RS_UNITS);

    logic                    src_dist_line_val;
    logic [DATA_W-1:0]       src_dist_line;
    logic                    dist_src_line_rdy;
    logic [NUM_RS_UNITS-1:0] dist_encoder_line_vals;
    logic [DATA_W-1:0]       dist_encoder_line;
    logic [NUM_RS_UNITS-1:0] encoder_dist_line_rdys;
    logic [UNIT_W-1:0]       dist_cur_unit;

    modport master (
        input  src_dist_line_val,
        input  src_dist_line,
        output dist_src_line_rdy,
        output dist_encoder_line_vals,
        output dist_encoder_line,
        input  encoder_dist_line_rdys,
        output dist_cur_unit
    );

    modport slave (
        output src_dist_line_val,
        output src_dist_line,
        input  dist_src_line_rdy,
        input  dist_encoder_line_vals,
        input  dist_encoder_line,
        output encoder_dist_line_rdys,
        input  dist_cur_unit
    );

endinterface

// File: rtl/rs_line_1_to_16_rs_block_rr_ptr.sv
// Block-granular round-robin pointer: stays on one unit for NUM_LINES advances, then moves on.
// The reducer instantiates the same counter so dispatch and drain order agree by construction.
module rs_block_rr_ptr
    import rs_encoder_pkg::*;
#(
    parameter int NUM_RS_UNITS = DEF_NUM_RS_UNITS,
    parameter int NUM_LINES    = DEF_NUM_LINES,
    localparam int UNIT_W      = rs_unit_idx_w(NUM_RS_UNITS),
    localparam int CNT_W       = line_cnt_w(NUM_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [UNIT_W-1:0] cur_unit
);

    localparam logic [CNT_W-1:0]  LAST_LINE = CNT_W'(NUM_LINES - 1);
    localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(NUM_RS_UNITS - 1);

    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic [UNIT_W-1:0] wr_unit_q, wr_unit_d;

    // Count lines within the block; on the last line move to the next unit, wrapping by explicit compare.
    always_comb begin
        line_cnt_d = line_cnt_q;
        wr_unit_d  = wr_unit_q;
        if (advance) begin
            if (line_cnt_q == LAST_LINE) begin
                line_cnt_d = '0;
                wr_unit_d  = (wr_unit_q == LAST_UNIT) ? '0 : wr_unit_q + UNIT_W'(1);
            end else begin
                line_cnt_d = line_cnt_q + CNT_W'(1);
            end
        end
    end

    // Pointer state; active-low synchronous reset restarts at unit 0, line 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_cnt_q <= '0;
            wr_unit_q  <= '0;
        end else begin
            line_cnt_q <= line_cnt_d;
            wr_unit_q  <= wr_unit_d;
        end
    end

    assign cur_unit = wr_unit_q;

endmodule

// File: rtl/rs_line_1_to_16.sv
// Line distributor ahead of the RS encoder array: whole blocks of lines go round-robin to the units.
// One registered output stage; a stalled target unit holds the line rather than skipping ahead,
// because the downstream reducer drains units in this exact order.
module rs_line_1_to_16
    import rs_encoder_pkg::*;
#(
    parameter int NUM_RS_UNITS = DEF_NUM_RS_UNITS,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_LINES    = DEF_NUM_LINES,
    localparam int UNIT_W      = rs_unit_idx_w(NUM_RS_UNITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    rs_line_1_to_16_if.master    bus
);

    localparam logic [NUM_RS_UNITS-1:0] ONE_HOT_BASE = NUM_RS_UNITS'(1);

    logic              out_val_q, out_val_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [UNIT_W-1:0] out_unit_q, out_unit_d;
    logic [UNIT_W-1:0] wr_unit;
    logic              out_fire;
    logic              in_fire;
    logic              src_rdy;

    // Only the targeted unit's ready matters; the register frees up in the same cycle it drains.
    assign out_fire = out_val_q & bus.encoder_dist_line_rdys[out_unit_q];
    assign src_rdy  = ~out_val_q | out_fire;
    assign in_fire  = bus.src_dist_line_val & src_rdy;

    rs_block_rr_ptr #(
        .NUM_RS_UNITS (NUM_RS_UNITS),
        .NUM_LINES    (NUM_LINES)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .advance  (in_fire),
        .cur_unit (wr_unit)
    );

    // Load a new line on input handshake (even while draining), otherwise drop valid once drained.
    always_comb begin
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_unit_d = out_unit_q;
        if (in_fire) begin
            out_val_d  = 1'b1;
            out_data_d = bus.src_dist_line;
            out_unit_d = wr_unit;
        end else if (out_fire) begin
            out_val_d  = 1'b0;
        end
    end

    // Output register; reset discards any pending line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_unit_q <= '0;
        end else begin
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_unit_q <= out_unit_d;
        end
    end

    assign bus.dist_src_line_rdy      = src_rdy;
    assign bus.dist_encoder_line_vals = out_val_q ? (ONE_HOT_BASE << out_unit_q) : '0;
    assign bus.dist_encoder_line      = out_data_q;
    assign bus.dist_cur_unit          = wr_unit;

endmodule

// File: tb/tb_rs_line_1_to_16.sv
// Bench for rs_line_1_to_16: three configurations (16x8, 5x3, 16x1) checked against a
// block-order model every cycle, plus directed literal expectations.
module tb_rs_line_1_to_16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rs_line_1_to_16_if #(.NUM_RS_UNITS(16), .DATA_W(256)) if_a ();
    rs_line_1_to_16_if #(.NUM_RS_UNITS(5),  .DATA_W(256)) if_b ();
    rs_line_1_to_16_if #(.NUM_RS_UNITS(16), .DATA_W(256)) if_c ();

    rs_line_1_to_16 #(.NUM_RS_UNITS(16), .DATA_W(256), .NUM_LINES(8)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    rs_line_1_to_16 #(.NUM_RS_UNITS(5), .DATA_W(256), .NUM_LINES(3)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b)
    );
    rs_line_1_to_16 #(.NUM_RS_UNITS(16), .DATA_W(256), .NUM_LINES(1)) dut_c (
        .clk (clk), .rst (rst), .bus (if_c)
    );

    // Model: line k since reset belongs to unit (k / lines) % units; one line may sit in the output slot.
    int           nu [3] = '{16, 5, 16};
    int           nl [3] = '{8, 3, 1};
    bit           m_val  [3];
    int           m_unit [3];
    logic [255:0] m_data [3];
    int           m_idx  [3];
    int           m_dcnt [3];
    bit           m_post [3];

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int id, input logic r, input logic sv, input logic [255:0] sl,
                              input logic [15:0] rdys, input logic [15:0] vals,
                              input logic [255:0] line, input logic srdy, input int cur);
        bit o_fire, i_fire;
        if (!r) begin
            m_val[id]  = 1'b0;
            m_unit[id] = 0;
            m_data[id] = '0;
            m_idx[id]  = 0;
            m_post[id] = 1'b1;
            return;
        end
        check_output($sformatf("dut%0d_cur_unit", id), 256'(cur), 256'((m_idx[id] / nl[id]) % nu[id]));
        check_output($sformatf("dut%0d_vals", id), 256'(vals),
                     m_val[id] ? (256'(1) << m_unit[id]) : 256'(0));
        if (m_val[id])
            check_output($sformatf("dut%0d_line", id), line, m_data[id]);
        if (m_post[id])
            check_output($sformatf("dut%0d_line_after_reset", id), line, 256'(0));
        m_post[id] = 1'b0;
        o_fire = m_val[id] && rdys[m_unit[id]];
        check_output($sformatf("dut%0d_src_rdy", id), 256'(srdy), 256'(!m_val[id] || o_fire));
        i_fire = sv && (!m_val[id] || o_fire);
        if (o_fire) m_dcnt[id]++;
        if (i_fire) begin
            m_val[id]  = 1'b1;
            m_unit[id] = (m_idx[id] / nl[id]) % nu[id];
            m_data[id] = sl;
            m_idx[id]++;
        end else if (o_fire) begin
            m_val[id]  = 1'b0;
        end
    endtask

    // Single compare process: one cycle-by-cycle check of all three DUTs just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            model_step(0, rst, if_a.src_dist_line_val, if_a.src_dist_line, if_a.encoder_dist_line_rdys,
                       if_a.dist_encoder_line_vals, if_a.dist_encoder_line, if_a.dist_src_line_rdy,
                       32'(if_a.dist_cur_unit));
            model_step(1, rst, if_b.src_dist_line_val, if_b.src_dist_line, 16'(if_b.encoder_dist_line_rdys),
                       16'(if_b.dist_encoder_line_vals), if_b.dist_encoder_line, if_b.dist_src_line_rdy,
                       32'(if_b.dist_cur_unit));
            model_step(2, rst, if_c.src_dist_line_val, if_c.src_dist_line, if_c.encoder_dist_line_rdys,
                       if_c.dist_encoder_line_vals, if_c.dist_encoder_line, if_c.dist_src_line_rdy,
                       32'(if_c.dist_cur_unit));
        end
    end

    task automatic drive(input int id, input logic v, input logic [255:0] d);
        case (id)
            0:       begin if_a.src_dist_line_val = v; if_a.src_dist_line = d; end
            1:       begin if_b.src_dist_line_val = v; if_b.src_dist_line = d; end
            default: begin if_c.src_dist_line_val = v; if_c.src_dist_line = d; end
        endcase
    endtask

    task automatic set_rdys(input int id, input logic [15:0] r);
        case (id)
            0:       if_a.encoder_dist_line_rdys = r;
            1:       if_b.encoder_dist_line_rdys = r[4:0];
            default: if_c.encoder_dist_line_rdys = r;
        endcase
    endtask

    function automatic logic src_rdy(input int id);
        case (id)
            0:       return if_a.dist_src_line_rdy;
            1:       return if_b.dist_src_line_rdy;
            default: return if_c.dist_src_line_rdy;
        endcase
    endfunction

    // Offer one line (called at a falling edge); returns at the falling edge after it was accepted.
    task automatic apply_stimulus(input int id, input logic [255:0] d);
        bit ok = 1'b0;
        drive(id, 1'b1, d);
        for (int k = 0; k < 64 && !ok; k++) begin
            #4;
            ok = src_rdy(id);
            @(negedge clk);
        end
        drive(id, 1'b0, d);
        check_output($sformatf("dut%0d_accept", id), 256'(ok), 256'(1));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        time t0;
        int  sent;
        bit  pending;

        for (int id = 0; id < 3; id++) begin
            drive(id, 1'b0, '0);
            set_rdys(id, 16'hFFFF);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_output("reset_vals", 256'(if_a.dist_encoder_line_vals), 256'(0));
        check_output("reset_line", if_a.dist_encoder_line, 256'(0));
        check_output("reset_cur_unit", 256'(if_a.dist_cur_unit), 256'(0));
        check_output("reset_src_rdy", 256'(if_a.dist_src_line_rdy), 256'(1));

        // 131 back-to-back lines: 16 blocks of 8 then 3 more lines wrapping back to unit 0.
        t0 = $time;
        for (int i = 0; i < 131; i++) begin
            apply_stimulus(0, 256'(i));
            if (i == 8)  check_output("a_line8_vals", 256'(if_a.dist_encoder_line_vals), 256'(16'h0002));
            if (i == 31) begin
                check_output("a_line31_vals", 256'(if_a.dist_encoder_line_vals), 256'(16'h0008));
                check_output("a_after32_cur_unit", 256'(if_a.dist_cur_unit), 256'(4));
            end
        end
        check_output("a_throughput_time", 256'($time - t0), 256'(1310));
        check_output("a_wrap_cur_unit", 256'(if_a.dist_cur_unit), 256'(0));
        check_output("a_line130_vals", 256'(if_a.dist_encoder_line_vals), 256'(16'h0001));
        check_output("a_line130_data", if_a.dist_encoder_line, 256'(130));

        // Stall: unit 1 not ready while line 8 is pending.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) apply_stimulus(0, 256'(i));
        set_rdys(0, 16'hFFFD);
        apply_stimulus(0, 256'(8));
        drive(0, 1'b1, 256'(9));
        for (int k = 0; k < 10; k++) begin
            #4;
            check_output("stall_vals", 256'(if_a.dist_encoder_line_vals), 256'(16'h0002));
            check_output("stall_data", if_a.dist_encoder_line, 256'(8));
            check_output("stall_src_rdy", 256'(if_a.dist_src_line_rdy), 256'(0));
            @(negedge clk);
        end
        set_rdys(0, 16'hFFFF);
        for (int i = 9; i <= 20; i++) apply_stimulus(0, 256'(i));
        check_output("a_line20_vals", 256'(if_a.dist_encoder_line_vals), 256'(16'h0004));

        // Reset mid-block with line 20 still pending on a stalled unit 2.
        set_rdys(0, 16'hFFFB);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_output("midrst_vals", 256'(if_a.dist_encoder_line_vals), 256'(0));
        check_output("midrst_line", if_a.dist_encoder_line, 256'(0));
        check_output("midrst_cur_unit", 256'(if_a.dist_cur_unit), 256'(0));
        check_output("midrst_src_rdy", 256'(if_a.dist_src_line_rdy), 256'(1));
        set_rdys(0, 16'hFFFF);
        apply_stimulus(0, 256'(777));
        check_output("midrst_first_vals", 256'(if_a.dist_encoder_line_vals), 256'(16'h0001));
        check_output("midrst_first_data", if_a.dist_encoder_line, 256'(777));
        for (int i = 1; i <= 8; i++) apply_stimulus(0, 256'(777 + i));
        check_output("midrst_line8_vals", 256'(if_a.dist_encoder_line_vals), 256'(16'h0002));
        check_output("midrst_line8_cur", 256'(if_a.dist_cur_unit), 256'(1));

        // 5 units x 3 lines with random source gaps and random readies.
        sent    = 0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 3000 && sent < 60; cyc++) begin
            if (!pending) drive(1, 1'b0, 256'(1000 + sent));
            set_rdys(1, 16'($urandom_range(0, 31)));
            if (!pending && $urandom_range(0, 1) == 1) begin
                pending = 1'b1;
                drive(1, 1'b1, 256'(1000 + sent));
            end
            #4;
            if (pending && src_rdy(1)) begin
                pending = 1'b0;
                sent++;
            end
            @(negedge clk);
        end
        drive(1, 1'b0, '0);
        set_rdys(1, 16'hFFFF);
        repeat (3) @(negedge clk);
        check_output("b_lines_accepted", 256'(sent), 256'(60));
        check_output("b_lines_delivered", 256'(m_dcnt[1]), 256'(60));
        check_output("b_cur_unit", 256'(if_b.dist_cur_unit), 256'(0));

        // One line per block: the unit advances on every line.
        t0 = $time;
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(2, 256'(i));
            check_output("c_vals", 256'(if_c.dist_encoder_line_vals), 256'(1) << (i % 16));
        end
        check_output("c_throughput_time", 256'($time - t0), 256'(170));
        check_output("c_line16_vals", 256'(if_c.dist_encoder_line_vals), 256'(16'h0001));
        check_output("c_line16_data", if_c.dist_encoder_line, 256'(16));
        check_output("c_cur_unit", 256'(if_c.dist_cur_unit), 256'(1));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
